da_bitplane_tapline: RTL

- Parametrised bit-serial tap delay line feeding the distributed-arithmetic FIR datapath.
- Each accepted sample shifts into an N_TAPS-deep delay line and snapshots all taps.
- The snapshot is emitted as DATA_W bit-planes, one plane per transfer. Each plane is an N_TAPS-bit vector in which bit k is one bit of tap k, grouped GROUP taps per DA lookup address.
- Compared with the previous generation, it adds width/depth/grouping parameters, valid/ready handshakes on both sides, selectable bit order, first/last plane flags, flush, and a line-full indicator.

---
 rtl/da_bitplane_tapline.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/da_bitplane_tapline.sv
// Bit-serial tap delay line for the distributed-arithmetic FIR datapath.
// Emits each post-shift tap snapshot as DATA_W bit-planes over valid/ready.
module da_bitplane_tapline #(
  parameter int N_TAPS    = 64,
  parameter int DATA_W    = 16,
  parameter int GROUP     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_TAPS-1:0] out_plane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              out_sign,
  output logic              line_full
);

  localparam int CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(N_TAPS + 1);

  localparam logic [CNT_W-1:0]  LAST = CNT_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(N_TAPS);

  generate
    if ((N_TAPS % GROUP) != 0 || DATA_W < 2) begin : g_bad_param
      $error("da_bitplane_tapline: illegal N_TAPS/GROUP/DATA_W");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    SERIAL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_tap  [N_TAPS];
  logic [DATA_W-1:0] r_snap [N_TAPS];
  logic [CNT_W-1:0]  r_cnt;
  logic [FILL_W-1:0] r_fill;

  logic              w_clr;
  logic              w_accept;
  logic              w_xfer;
  logic              w_last;
  logic              w_serial;
  logic [CNT_W-1:0]  w_sel;
  logic [N_TAPS-1:0] w_plane;

  assign w_clr    = reset | flush;
  assign w_serial = (r_state == SERIAL);
  assign w_accept = ~w_serial & in_valid;
  assign w_xfer   = w_serial & out_ready;
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next = SERIAL;
        end
      end
      SERIAL: begin
        if (out_ready && w_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Snapshot takes the post-shift line so tap 0 is the sample just accepted.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_tap[k]  <= '0;
        r_snap[k] <= '0;
      end
    end else if (w_accept) begin
      r_tap[0]  <= in_data;
      r_snap[0] <= in_data;
      for (int k = 1; k < N_TAPS; k++) begin
        r_tap[k]  <= r_tap[k-1];
        r_snap[k] <= r_tap[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_xfer && !w_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_fill <= '0;
    end else if (w_accept && (r_fill != FULL)) begin
      r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign w_sel = (LSB_FIRST != 0) ? r_cnt : (LAST - r_cnt);

  always_comb begin
    w_plane = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      w_plane[k] = r_snap[k][w_sel];
    end
  end

  // Idle outputs are forced to zero so a stale snapshot never leaks out.
  assign in_ready  = ~w_serial;
  assign out_valid = w_serial;
  assign out_plane = w_serial ? w_plane : '0;
  assign out_first = w_serial & (r_cnt == '0);
  assign out_last  = w_serial & w_last;
  assign out_sign  = w_serial & (w_sel == LAST);
  assign line_full = (r_fill == FULL);

endmodule
